mips32_dmem_responder: RTL and testbench
========================================

Name: mips32_dmem_responder

Overview:
- Data-memory slave answering the CPU datapath's MemRd/MemWr requests.
- Handshake-based: fixed, parameterised wait-state latency with a one-cycle ready pulse.
- Sits between the datapath load/store port and a word-organised RAM.
- Later serves as the memory stage's stall source for the pipelined core.

Parameters:
- DEPTH_LOG2, 8: memory holds 2^DEPTH_LOG2 32-bit words.
- WAIT_STATES, 2: extra cycles between request acceptance and response (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mem_rd  input  1  read request.
- mem_wr  input  1  write request.
- addr  input  32  byte address.
- wdata  input  32  write data.
- byte_en  input  4  write byte lanes; bit i enables wdata[8i+7:8i].
- rdata  output  32  read data, valid while ready=1, held afterwards.
- ready  output  1  one-cycle response pulse.
- err  output  1  error flag, valid while ready=1.
- busy  output  1  high from acceptance until the ready cycle, inclusive.

Behaviour:
- Clocking and reset
  - One clock. Reset is asynchronous and active-low.
  - Reset forces: state IDLE, wait counter 0, rdata=0, ready=0, err=0, busy=0.
  - Reset does not clear the RAM array; its contents are undefined after power-up.
- States: IDLE, WAIT, RESP.
- IDLE
  - Accepts a request on an edge where mem_rd|mem_wr=1.
  - On acceptance, latches addr, wdata, byte_en and op, and sets busy=1.
  - Goes to WAIT with counter=WAIT_STATES, or directly to RESP if WAIT_STATES=0.
- WAIT
  - Counter decrements each edge. Inputs are ignored.
  - Moves to RESP on the edge where the counter reaches 0.
- RESP
  - ready=1 for exactly one cycle, then IDLE, with busy=0 from the next cycle.
  - The next request can be accepted only from IDLE, so back-to-back requests cost one idle cycle.
- Latency: ready is high in cycle N+WAIT_STATES+1, where N is the acceptance cycle.
- Write commit
  - The RAM is written on the edge that enters RESP.
  - Only enabled bytes are written.
  - rdata is unchanged by writes.
- Read data
  - Loaded on the edge entering RESP from RAM[latched addr[DEPTH_LOG2+1:2]].
  - Held until the next read response or reset.
- Error conditions, each giving err=1 in RESP with no RAM write and rdata unchanged:
  - mem_rd and mem_wr both high at acceptance.
  - addr[1:0]!=0.
  - Any bit of addr[31:DEPTH_LOG2+2] set.
  - Write with byte_en=0 is legal: no bytes change and err=0.
- Reset mid-operation (WAIT or RESP) aborts the transaction.
  - No write is committed if reset arrives before the commit edge.
  - ready is not issued for the aborted request.
- Requests arriving while busy=1 are ignored, not queued. The master must hold or re-issue them after ready.
- Read-after-write to the same word in consecutive transactions returns the new data (the write has committed before the next acceptance).

Test Plan:
- Reset, then write 0xDEADBEEF to addr 0x10 with byte_en=0xF, then read 0x10 (WAIT_STATES=2) -> ready high 3 cycles after each acceptance, read rdata=0xDEADBEEF, err=0.
- Write 0x11223344 to 0x20, then write 0xAABBCCDD with byte_en=0x5, then read 0x20 -> 0x11BB33DD.
- Read 0x22 (misaligned); read 0x400 with DEPTH_LOG2=8 (out of range); request with mem_rd=mem_wr=1 -> each gives ready with err=1, rdata unchanged, memory unchanged.
- WAIT_STATES=0: read accepted at cycle N -> ready at N+1; busy high in N+1 only; a request held during busy is accepted at N+2.
- Write to 0x30 accepted, then rst_n pulled low during WAIT -> ready never asserted; all outputs 0 immediately; after reset, read 0x30 returns the old contents.
- Toggle mem_rd/addr during WAIT -> response matches the originally latched request and exactly one ready pulse occurs.

Source files
------------

// File: rtl/mips32_dmem_responder_if.sv
// -----------------------------------------------------------------------------
// mips32_dmem_responder_if
// Load/store bus between the datapath (master) and the data-memory
// responder (slave).
//   mem_rd, mem_wr  : read / write request strobes (master -> slave)
//   addr            : byte address                 (master -> slave)
//   wdata, byte_en  : write data and byte lanes    (master -> slave)
//   rdata           : read data, held after ready  (slave -> master)
//   ready           : one-cycle response pulse     (slave -> master)
//   err             : error flag, valid with ready (slave -> master)
//   busy            : transaction in flight        (slave -> master)
// -----------------------------------------------------------------------------
interface mips32_dmem_responder_if;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byte_en;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;

    modport master (
        output mem_rd, mem_wr, addr, wdata, byte_en,
        input  rdata, ready, err, busy
    );

    modport slave (
        input  mem_rd, mem_wr, addr, wdata, byte_en,
        output rdata, ready, err, busy
    );
endinterface

// File: rtl/mips32_dmem_responder.sv
// -----------------------------------------------------------------------------
// mips32_dmem_responder
// Data-memory slave for the MIPS32 datapath. A request is accepted in IDLE,
// waits WAIT_STATES cycles, then answers with a one-cycle ready pulse. The
// word RAM is written (enabled byte lanes only) and read data is loaded on the
// edge that enters RESP. Misaligned, out-of-range and read+write requests
// answer with err=1 and touch neither the RAM nor rdata.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset (RAM contents are not cleared)
//   bus   : mips32_dmem_responder_if.slave load/store bus
// -----------------------------------------------------------------------------
module mips32_dmem_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mips32_dmem_responder_if.slave  bus
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    logic [3:0]              r_cnt;
    logic [DEPTH_LOG2-1:0]   r_idx;
    logic [31:0]             r_wdata;
    logic [3:0]              r_be;
    logic                    r_is_rd;
    logic                    r_is_wr;
    logic                    r_req_err;
    logic [31:0]             r_rdata;
    logic                    r_ready;
    logic                    r_err;
    logic                    r_busy;
    logic [31:0]             r_mem [DEPTH];

    logic                    w_req;
    logic                    w_req_err;
    logic                    w_enter_resp;
    logic [DEPTH_LOG2-1:0]   w_c_idx;
    logic [31:0]             w_c_wdata;
    logic [3:0]              w_c_be;
    logic                    w_c_rd;
    logic                    w_c_wr;
    logic                    w_c_err;
    logic                    w_commit_wr;
    logic                    w_load_rd;

    // Address fault: not word aligned, or beyond the implemented word range.
    function automatic logic addr_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (DEPTH_LOG2 + 2)) != 32'd0);
    endfunction

    assign w_req     = bus.mem_rd | bus.mem_wr;
    assign w_req_err = (bus.mem_rd & bus.mem_wr) | addr_fault(bus.addr);

    // Commit source: with zero wait states the commit edge is also the
    // acceptance edge, so the live bus is used instead of the latched copy.
    always_comb begin
        w_c_idx   = r_idx;
        w_c_wdata = r_wdata;
        w_c_be    = r_be;
        w_c_rd    = r_is_rd;
        w_c_wr    = r_is_wr;
        w_c_err   = r_req_err;
        if (r_state == ST_IDLE) begin
            w_c_idx   = bus.addr[DEPTH_LOG2+1:2];
            w_c_wdata = bus.wdata;
            w_c_be    = bus.byte_en;
            w_c_rd    = bus.mem_rd;
            w_c_wr    = bus.mem_wr;
            w_c_err   = w_req_err;
        end else begin
            w_c_idx   = r_idx;
        end
    end

    // Detect the edge that moves the FSM into RESP.
    always_comb begin
        w_enter_resp = 1'b0;
        case (r_state)
            ST_IDLE: w_enter_resp = w_req && (WAIT_STATES == 0);
            ST_WAIT: w_enter_resp = (r_cnt == 4'd1);
            default: w_enter_resp = 1'b0;
        endcase
    end

    // rst_n gates the write so a request seen during reset never lands.
    assign w_commit_wr = w_enter_resp & w_c_wr & ~w_c_err & rst_n;
    assign w_load_rd   = w_enter_resp & w_c_rd & ~w_c_err;

    // Request FSM with latched request, wait counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_idx     <= '0;
            r_wdata   <= 32'd0;
            r_be      <= 4'd0;
            r_is_rd   <= 1'b0;
            r_is_wr   <= 1'b0;
            r_req_err <= 1'b0;
            r_rdata   <= 32'd0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            if (w_load_rd) begin
                r_rdata <= r_mem[w_c_idx];
            end
            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                    if (w_req) begin
                        r_idx     <= bus.addr[DEPTH_LOG2+1:2];
                        r_wdata   <= bus.wdata;
                        r_be      <= bus.byte_en;
                        r_is_rd   <= bus.mem_rd;
                        r_is_wr   <= bus.mem_wr;
                        r_req_err <= w_req_err;
                        r_busy    <= 1'b1;
                        if (WAIT_STATES == 0) begin
                            r_state <= ST_RESP;
                            r_ready <= 1'b1;
                            r_err   <= w_req_err;
                            r_cnt   <= 4'd0;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= 4'(WAIT_STATES);
                        end
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_state <= ST_RESP;
                        r_ready <= 1'b1;
                        r_err   <= r_req_err;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt   <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    // Word RAM, byte-lane write on the commit edge; deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_commit_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (w_c_be[b]) begin
                    r_mem[w_c_idx][8*b +: 8] <= w_c_wdata[8*b +: 8];
                end
            end
        end
    end

    assign bus.rdata = r_rdata;
    assign bus.ready = r_ready;
    assign bus.err   = r_err;
    assign bus.busy  = r_busy;

endmodule

// File: tb/tb_mips32_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_mips32_dmem_responder
// Directed bench for mips32_dmem_responder: dut0 uses WAIT_STATES=2, dut1 uses
// WAIT_STATES=0. Drivers push the hand-computed response (data, err, cycle of
// the ready pulse) into a per-DUT queue; monitors pop and compare on ready.
// -----------------------------------------------------------------------------
module tb_mips32_dmem_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;

    // Cycle index: value seen between posedge k and posedge k+1 is k.
    always @(posedge clk) cyc <= cyc + 1;

    mips32_dmem_responder_if bus0 ();
    mips32_dmem_responder_if bus1 ();

    mips32_dmem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(2)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    mips32_dmem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(0)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic [31:0] at;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int checks = 0;
    int errors = 0;
    int rdy0_cnt = 0;
    int rdy1_cnt = 0;
    int exp_rdy0 = 0;
    int exp_rdy1 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor for dut0: every ready pulse must match the oldest expectation.
    always @(negedge clk) begin : mon0
        exp_t e;
        if (bus0.ready === 1'b1) begin
            rdy0_cnt++;
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL d0_unexpected_ready: got ready at cycle %0d expected none", cyc);
            end else begin
                e = q0.pop_front();
                check("d0_rdata", bus0.rdata, e.data);
                check("d0_err", 32'(bus0.err), 32'(e.err));
                check("d0_ready_cycle", 32'(cyc), e.at);
                check("d0_busy_at_ready", 32'(bus0.busy), 32'd1);
            end
        end
    end

    // Monitor for dut1 (zero wait states).
    always @(negedge clk) begin : mon1
        exp_t e;
        if (bus1.ready === 1'b1) begin
            rdy1_cnt++;
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL d1_unexpected_ready: got ready at cycle %0d expected none", cyc);
            end else begin
                e = q1.pop_front();
                check("d1_rdata", bus1.rdata, e.data);
                check("d1_err", 32'(bus1.err), 32'(e.err));
                check("d1_ready_cycle", 32'(cyc), e.at);
                check("d1_busy_at_ready", 32'(bus1.busy), 32'd1);
            end
        end
    end

    task automatic wait_idle0();
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (bus0.busy === 1'b0) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL d0_idle_timeout: got busy=%b expected 0", bus0.busy);
        end
    endtask

    task automatic wait_idle1();
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (bus1.busy === 1'b0) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL d1_idle_timeout: got busy=%b expected 0", bus1.busy);
        end
    endtask

    // Issue one request to dut0; drop=1 means no response is expected.
    task automatic issue0(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be,
                          input logic [31:0] edata, input logic eerr, input bit drop);
        wait_idle0();
        bus0.mem_rd  = rd;
        bus0.mem_wr  = wr;
        bus0.addr    = a;
        bus0.wdata   = d;
        bus0.byte_en = be;
        @(posedge clk);
        #1;
        if (!drop) begin
            q0.push_back('{data: edata, err: eerr, at: 32'(cyc + 2)});
            exp_rdy0++;
        end
        @(negedge clk);
        bus0.mem_rd = 1'b0;
        bus0.mem_wr = 1'b0;
    endtask

    task automatic issue1(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be,
                          input logic [31:0] edata, input logic eerr);
        wait_idle1();
        bus1.mem_rd  = rd;
        bus1.mem_wr  = wr;
        bus1.addr    = a;
        bus1.wdata   = d;
        bus1.byte_en = be;
        @(posedge clk);
        #1;
        q1.push_back('{data: edata, err: eerr, at: 32'(cyc)});
        exp_rdy1++;
        @(negedge clk);
        bus1.mem_rd = 1'b0;
        bus1.mem_wr = 1'b0;
    endtask

    initial begin
        int p;
        bus0.mem_rd = 1'b0; bus0.mem_wr = 1'b0; bus0.addr = 32'd0;
        bus0.wdata = 32'd0; bus0.byte_en = 4'd0;
        bus1.mem_rd = 1'b0; bus1.mem_wr = 1'b0; bus1.addr = 32'd0;
        bus1.wdata = 32'd0; bus1.byte_en = 4'd0;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rdata", bus0.rdata, 32'd0);
        check("rst_ready", 32'(bus0.ready), 32'd0);
        check("rst_err", 32'(bus0.err), 32'd0);
        check("rst_busy", 32'(bus0.busy), 32'd0);
        check("rst_d1_busy", 32'(bus1.busy), 32'd0);
        rst_n = 1'b1;

        // Full-word write, read back.
        issue0(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 1'b0);
        issue0(1'b1, 1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 1'b0);
        // Byte-lane merge: lanes 0 and 2 overwritten.
        issue0(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0);
        issue0(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 32'hDEADBEEF, 1'b0, 1'b0);
        issue0(1'b1, 1'b0, 32'h20, 32'h0,        4'h0, 32'h11BB33DD, 1'b0, 1'b0);
        // Error cases: rdata stays at the last read value.
        issue0(1'b1, 1'b0, 32'h22,  32'h0,        4'h0, 32'h11BB33DD, 1'b1, 1'b0);
        issue0(1'b1, 1'b0, 32'h400, 32'h0,        4'h0, 32'h11BB33DD, 1'b1, 1'b0);
        issue0(1'b1, 1'b1, 32'h10,  32'h0,        4'hF, 32'h11BB33DD, 1'b1, 1'b0);
        issue0(1'b0, 1'b1, 32'h21,  32'hFFFFFFFF, 4'hF, 32'h11BB33DD, 1'b1, 1'b0);
        issue0(1'b0, 1'b1, 32'h410, 32'hFFFFFFFF, 4'hF, 32'h11BB33DD, 1'b1, 1'b0);
        // Write with no lanes enabled is legal and changes nothing.
        issue0(1'b0, 1'b1, 32'h10,  32'h00000000, 4'h0, 32'h11BB33DD, 1'b0, 1'b0);
        // Memory must be untouched by all of the above.
        issue0(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b0);
        issue0(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 1'b0);

        // Reset during WAIT aborts the write to 0x30.
        issue0(1'b0, 1'b1, 32'h30, 32'h0BADF00D, 4'hF, 32'h11BB33DD, 1'b0, 1'b0);
        issue0(1'b0, 1'b1, 32'h30, 32'h55555555, 4'hF, 32'h0,        1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(bus0.ready), 32'd0);
        check("abort_busy", 32'(bus0.busy), 32'd0);
        check("abort_err", 32'(bus0.err), 32'd0);
        check("abort_rdata", bus0.rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue0(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 32'h0BADF00D, 1'b0, 1'b0);

        // Inputs toggled during WAIT/RESP are ignored.
        wait_idle0();
        bus0.mem_rd = 1'b1; bus0.addr = 32'h20;
        @(posedge clk);
        #1;
        q0.push_back('{data: 32'h11BB33DD, err: 1'b0, at: 32'(cyc + 2)});
        exp_rdy0++;
        @(negedge clk);
        bus0.mem_rd = 1'b0; bus0.addr = 32'h30;
        @(negedge clk);
        bus0.mem_rd = 1'b1; bus0.mem_wr = 1'b1; bus0.addr = 32'h24;
        bus0.wdata = 32'h0; bus0.byte_en = 4'hF;
        @(negedge clk);
        bus0.mem_rd = 1'b0; bus0.mem_wr = 1'b0;

        // Zero wait states: ready next cycle, held request waits one idle cycle.
        issue1(1'b0, 1'b1, 32'h40, 32'h12345678, 4'hF, 32'h0, 1'b0);
        wait_idle1();
        bus1.mem_rd = 1'b1; bus1.addr = 32'h40;
        @(posedge clk);
        #1;
        p = cyc;
        q1.push_back('{data: 32'h12345678, err: 1'b0, at: 32'(p)});
        exp_rdy1++;
        @(negedge clk);
        check("ws0_busy_resp", 32'(bus1.busy), 32'd1);
        @(negedge clk);
        check("ws0_busy_idle", 32'(bus1.busy), 32'd0);
        check("ws0_ready_idle", 32'(bus1.ready), 32'd0);
        @(posedge clk);
        #1;
        q1.push_back('{data: 32'h12345678, err: 1'b0, at: 32'(p + 2)});
        exp_rdy1++;
        @(negedge clk);
        bus1.mem_rd = 1'b0;

        // Drain: bounded wait for all expected responses.
        for (int i = 0; i < 30 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("d0_pending", 32'(q0.size()), 32'd0);
        check("d1_pending", 32'(q1.size()), 32'd0);
        check("d0_ready_count", 32'(rdy0_cnt), 32'(exp_rdy0));
        check("d1_ready_count", 32'(rdy1_cnt), 32'(exp_rdy1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
